// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one pipelined multiplier among N requesters
module mul_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int MUL_LAT = 2,
  localparam int IDW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_product,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic [2*W-1:0]   resp_product,
  output logic             busy
);

  localparam int STAGES = MUL_LAT + 1;

  logic [IDW-1:0] last_grant;
  logic [N-1:0]   above_last;
  logic [N-1:0]   masked;
  logic [N-1:0]   pick;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic [W-1:0]   grant_a;
  logic [W-1:0]   grant_b;
  logic           transfer;

  logic [STAGES-1:0] tag_valid;
  logic [IDW-1:0]    tag_id [STAGES];

  // Requesters above last_grant get first pick; if none are valid, wrap to the lowest index.
  always_comb begin
    above_last = '0;
    for (int i = 0; i < N; i++) begin
      above_last[i] = (IDW'(i) > last_grant);
    end
    masked = req_valid & above_last;
    pick   = (|masked) ? masked : req_valid;
  end

  // Downward scan so the lowest set bit of pick wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        grant_id = IDW'(i);
        grant_a  = req_a[i*W +: W];
        grant_b  = req_b[i*W +: W];
      end
    end
  end

  assign transfer  = |pick;
  assign req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(N - 1);
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      mul_start <= transfer;
      if (transfer) begin
        last_grant <= grant_id;
        mul_a      <= grant_a;
        mul_b      <= grant_b;
      end
    end
  end

  // Tag pipeline: the final stage lines up with the product leaving the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_valid[0] <= transfer;
      tag_id[0]    <= grant_id;
      for (int k = 1; k < STAGES; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  assign resp_valid   = tag_valid[STAGES-1];
  assign resp_id      = tag_id[STAGES-1];
  assign resp_product = mul_product;
  assign busy         = |tag_valid;

endmodule
